// File: rtl/ddr4_v2_2_20_mc_act_arb_ap.sv
// Round-robin activate arbiter over four group slots with tRRD/tFAW pacing.
// sel/winValid are registered; grant is the combinational accept pulse back to the winner.
module ddr4_v2_2_20_mc_act_arb_ap #(
  parameter int unsigned TRRD = 4,
  parameter int unsigned TFAW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       cmdRdy,
  output logic [3:0] sel,
  output logic       winValid,
  output logic [3:0] grant,
  output logic       rrdBlock,
  output logic       fawBlock
);

  localparam logic [3:0] RrdLoad = 4'(TRRD - 1);
  localparam logic [5:0] FawLoad = 6'(TFAW - 1);

  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      rrd_q, rrd_d;
  logic [3:0][5:0] faw_q, faw_d;
  logic [3:0]      sel_d;
  logic            win_valid_d;
  logic            rrd_block_d, faw_block_d;

  logic            accept;
  logic [1:0]      grant_idx;
  logic [3:0]      elig;
  logic [3:0]      cand;
  logic            cand_any;
  logic            rrd_ok, faw_ok;
  logic            faw_loaded;
  logic [3:0]      faw_busy;
  logic [5:0]      faw_dec;
  logic [1:0]      scan;

  assign grant  = rst_n ? (sel & req & {4{winValid & cmdRdy}}) : 4'b0000;
  assign accept = |grant;

  always_comb begin
    grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) grant_idx = 2'(i);
    end
  end

  assign ptr_d = accept ? grant_idx : ptr_q;

  // Counter values describe the cycle after this edge, so a pick made now is legal when it lands.
  always_comb begin
    if (accept) rrd_d = RrdLoad;
    else if (rrd_q != 4'd0) rrd_d = rrd_q - 4'd1;
    else rrd_d = 4'd0;
  end

  assign rrd_ok = (rrd_d == 4'd0);

  always_comb begin
    faw_loaded = 1'b0;
    faw_d      = faw_q;
    faw_busy   = 4'b0000;
    faw_dec    = 6'd0;
    for (int i = 0; i < 4; i++) begin
      faw_dec  = (faw_q[i] != 6'd0) ? faw_q[i] - 6'd1 : 6'd0;
      faw_d[i] = faw_dec;
      if (accept && !faw_loaded && faw_dec == 6'd0) begin
        faw_d[i]   = FawLoad;
        faw_loaded = 1'b1;
      end
      faw_busy[i] = (faw_d[i] != 6'd0);
    end
  end

  assign faw_ok = ~&faw_busy;

  // The just-granted group is masked so its still-high level request is not picked again.
  assign elig = req & ~grant;

  always_comb begin
    cand     = 4'b0000;
    cand_any = 1'b0;
    scan     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan = ptr_d + 2'(k);
      if (!cand_any && elig[scan]) begin
        cand[scan] = 1'b1;
        cand_any   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_d       = 4'b0000;
    win_valid_d = 1'b0;
    rrd_block_d = 1'b0;
    faw_block_d = 1'b0;
    if (winValid && !accept) begin
      if (|(sel & req)) begin
        sel_d       = sel;
        win_valid_d = 1'b1;
      end
    end else begin
      rrd_block_d = cand_any & ~rrd_ok;
      faw_block_d = cand_any & ~faw_ok;
      if (cand_any && rrd_ok && faw_ok) begin
        sel_d       = cand;
        win_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q    <= 2'd3;
      rrd_q    <= 4'd0;
      faw_q    <= '0;
      sel      <= 4'b0000;
      winValid <= 1'b0;
      rrdBlock <= 1'b0;
      fawBlock <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rrd_q    <= rrd_d;
      faw_q    <= faw_d;
      sel      <= sel_d;
      winValid <= win_valid_d;
      rrdBlock <= rrd_block_d;
      fawBlock <= faw_block_d;
    end
  end

endmodule

// File: tb/tb_ddr4_v2_2_20_mc_act_arb_ap.sv
// Scoreboard bench: stimulus queues expected grants/status per cycle, a negedge monitor compares.
module tb_ddr4_v2_2_20_mc_act_arb_ap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, rdy_a, wv_a, rrd_a, faw_a;
  logic [3:0] req_a, sel_a, grant_a;
  logic       rst_b, rdy_b, wv_b, rrd_b, faw_b;
  logic [3:0] req_b, sel_b, grant_b;

  ddr4_v2_2_20_mc_act_arb_ap #(.TRRD(4), .TFAW(16)) dut_a (
    .clk(clk), .rst_n(rst_a), .req(req_a), .cmdRdy(rdy_a), .sel(sel_a), .winValid(wv_a),
    .grant(grant_a), .rrdBlock(rrd_a), .fawBlock(faw_a)
  );

  ddr4_v2_2_20_mc_act_arb_ap #(.TRRD(1), .TFAW(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b), .cmdRdy(rdy_b), .sel(sel_b), .winValid(wv_b),
    .grant(grant_b), .rrdBlock(rrd_b), .fawBlock(faw_b)
  );

  typedef struct packed {
    int         cyc;
    logic [3:0] g;
  } gexp_t;

  typedef struct packed {
    int         cyc;
    logic [3:0] sel;
    logic       wv;
    logic [3:0] g;
    logic       chk_blk;
    logic       rrd;
    logic       faw;
  } sexp_t;

  gexp_t gqa[$];
  gexp_t gqb[$];
  sexp_t sqa[$];
  sexp_t sqb[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  logic  done   = 1'b0;

  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_sa(input logic [3:0] s, input logic v, input logic [3:0] g,
                         input logic c, input logic r, input logic f);
    sexp_t e;
    e = '{cyc: cyc, sel: s, wv: v, g: g, chk_blk: c, rrd: r, faw: f};
    sqa.push_back(e);
  endtask

  task automatic push_sb(input logic [3:0] s, input logic v, input logic [3:0] g,
                         input logic c, input logic r, input logic f);
    sexp_t e;
    e = '{cyc: cyc, sel: s, wv: v, g: g, chk_blk: c, rrd: r, faw: f};
    sqb.push_back(e);
  endtask

  task automatic push_ga(input int c, input logic [3:0] g);
    gexp_t e;
    e = '{cyc: c, g: g};
    gqa.push_back(e);
  endtask

  task automatic push_gb(input int c, input logic [3:0] g);
    gexp_t e;
    e = '{cyc: c, g: g};
    gqb.push_back(e);
  endtask

  task automatic cmp_status(input string nm, input sexp_t e, input logic [3:0] s, input logic v,
                            input logic [3:0] g, input logic r, input logic f);
    logic bad;
    n_cmp++;
    bad = (e.cyc != cyc) || (s !== e.sel) || (v !== e.wv) || (g !== e.g);
    if (e.chk_blk) bad = bad || (r !== e.rrd) || (f !== e.faw);
    if (bad) begin
      n_fail++;
      $display("FAIL status_%s cyc=%0d: got sel=%b wv=%b grant=%b rrd=%b faw=%b, want sel=%b wv=%b grant=%b rrd=%b faw=%b (blk checked=%b, due cyc=%0d)",
               nm, cyc, s, v, g, r, f, e.sel, e.wv, e.g, e.rrd, e.faw, e.chk_blk, e.cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    sexp_t se;
    gexp_t ge;
    while (sqa.size() > 0 && sqa[0].cyc <= cyc) begin
      se = sqa.pop_front();
      cmp_status("A", se, sel_a, wv_a, grant_a, rrd_a, faw_a);
    end
    while (sqb.size() > 0 && sqb[0].cyc <= cyc) begin
      se = sqb.pop_front();
      cmp_status("B", se, sel_b, wv_b, grant_b, rrd_b, faw_b);
    end
    while (gqa.size() > 0 && gqa[0].cyc < cyc) begin
      ge = gqa.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL grant_A_missing cyc=%0d: got none, want grant=%b at cyc=%0d", cyc, ge.g, ge.cyc);
    end
    if (grant_a !== 4'b0000) begin
      n_cmp++;
      if (gqa.size() > 0 && gqa[0].cyc == cyc) begin
        ge = gqa.pop_front();
        if (ge.g !== grant_a) begin
          n_fail++;
          $display("FAIL grant_A cyc=%0d: got grant=%b, want grant=%b", cyc, grant_a, ge.g);
        end
      end else begin
        n_fail++;
        $display("FAIL grant_A_unexpected cyc=%0d: got grant=%b, want grant=0000", cyc, grant_a);
      end
    end
    while (gqb.size() > 0 && gqb[0].cyc < cyc) begin
      ge = gqb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL grant_B_missing cyc=%0d: got none, want grant=%b at cyc=%0d", cyc, ge.g, ge.cyc);
    end
    if (grant_b !== 4'b0000) begin
      n_cmp++;
      if (gqb.size() > 0 && gqb[0].cyc == cyc) begin
        ge = gqb.pop_front();
        if (ge.g !== grant_b) begin
          n_fail++;
          $display("FAIL grant_B cyc=%0d: got grant=%b, want grant=%b", cyc, grant_b, ge.g);
        end
      end else begin
        n_fail++;
        $display("FAIL grant_B_unexpected cyc=%0d: got grant=%b, want grant=0000", cyc, grant_b);
      end
    end
    if (done) begin
      n_cmp  += gqa.size() + gqb.size() + sqa.size() + sqb.size();
      n_fail += gqa.size() + gqb.size() + sqa.size() + sqb.size();
      if (gqa.size() + gqb.size() + sqa.size() + sqb.size() != 0)
        $display("FAIL leftover_expectations: got %0d unchecked entries, want 0",
                 gqa.size() + gqb.size() + sqa.size() + sqb.size());
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    req_a = 4'hF;
    rdy_a = 1'b1;
    req_b = 4'b0101;
    rdy_b = 1'b1;

    // Reset held three cycles with everything requesting.
    for (int k = 1; k <= 3; k++) begin
      wait_to(k);
      push_sa(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
      if (k == 1) push_sb(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;

    wait_to(4);
    push_sa(4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    push_sb(4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    // tRRD=4 rotation, fifth accept waits for the tFAW window.
    push_ga(4, 4'b0001);
    push_ga(8, 4'b0010);
    push_ga(12, 4'b0100);
    push_ga(16, 4'b1000);
    push_ga(20, 4'b0001);
    push_ga(24, 4'b0010);
    // TRRD=1: two requesters alternate every cycle.
    for (int k = 0; k < 8; k++) push_gb(4 + k, (k % 2 == 1) ? 4'b0100 : 4'b0001);

    wait_to(7);
    push_sa(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);

    wait_to(12);
    req_b = 4'b0000;

    wait_to(25);
    rdy_a = 1'b0;
    for (int k = 28; k <= 32; k++) begin
      wait_to(k);
      push_sa(4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    wait_to(33);
    rdy_a = 1'b1;
    push_ga(33, 4'b0100);

    wait_to(37);
    push_sa(4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    push_ga(37, 4'b1000);

    // Stall on group 1, then withdraw it: cancel, then group 3 is picked.
    wait_to(38);
    rdy_a = 1'b0;
    req_a = 4'b1010;
    wait_to(41);
    push_sa(4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    wait_to(42);
    push_sa(4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    req_a = 4'b1000;
    wait_to(43);
    push_sa(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    wait_to(44);
    push_sa(4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset while tRRD is blocking: first accept after release is immediate, group 0 first.
    wait_to(45);
    rdy_a = 1'b1;
    req_a = 4'hF;
    push_ga(45, 4'b1000);
    wait_to(46);
    push_sa(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    rst_a = 1'b0;
    wait_to(47);
    push_sa(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    rst_a = 1'b1;
    wait_to(48);
    push_sa(4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    push_ga(48, 4'b0001);
    push_ga(52, 4'b0010);
    wait_to(53);
    req_a = 4'b0000;

    wait_to(60);
    done = 1'b1;
  end

endmodule
